// File: rtl/aes_pkg.sv
// Shared AES definitions: inverse S-box, GF(2^8) arithmetic, block typedef and core FSM states.
// Imported by the forward/inverse combinational blocks and the iterative inverse core.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int BLOCK_W   = 128;

  typedef logic [BLOCK_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } core_state_e;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Source byte position for InvShiftRows; byte i sits at row i%4, column i/4.
  function automatic int inv_shift_src(input int i);
    return ((((i / 4) - (i % 4)) + 4) % 4) * 4 + (i % 4);
  endfunction

endpackage

// File: rtl/aes_inv_iter_core_if.sv
// Key-load, ciphertext-in and plaintext-out handshake bundle of the iterative inverse core.
interface aes_inv_iter_core_if;
  import aes_pkg::*;

  logic               key_wr;
  logic [3:0]         key_idx;
  logic [BLOCK_W-1:0] key_data;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;

  modport master (
    output key_wr, key_idx, key_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  key_wr, key_idx, key_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless this is the final (r=0) round.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_state_t state_i,
  input  aes_state_t key_i,
  input  logic       last_i,
  output aes_state_t state_o
);

  logic [7:0] ark_s [16];
  aes_state_t ark_flat_s;
  aes_state_t mix_s;

  always_comb begin
    ark_flat_s = '0;
    for (int i = 0; i < 16; i++) begin
      ark_s[i] = inv_sub(state_i[8*(15 - inv_shift_src(i)) +: 8]) ^ key_i[8*(15 - i) +: 8];
      ark_flat_s[8*(15 - i) +: 8] = ark_s[i];
    end
  end

  // Column-wise multiply by the {0e,0b,0d,09} circulant.
  always_comb begin
    mix_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mix_s[8*(15 - (4*c + r)) +: 8] =
            gf_mul(ark_s[4*c + r],           8'h0e) ^
            gf_mul(ark_s[4*c + (r + 1) % 4], 8'h0b) ^
            gf_mul(ark_s[4*c + (r + 2) % 4], 8'h0d) ^
            gf_mul(ark_s[4*c + (r + 3) % 4], 8'h09);
      end
    end
  end

  assign state_o = last_i ? ark_flat_s : mix_s;

endmodule

// File: rtl/aes_inv_iter_core.sv
// Iterative AES inverse cipher: key file, IDLE/RUN/DONE control and RPC chained
// inverse rounds per clock; output is held until the consumer takes it.
module aes_inv_iter_core
  import aes_pkg::*;
#(
  parameter int RPC = 1,
  parameter int NR  = NR_AES128
) (
  input logic                clk,
  input logic                rst,
  aes_inv_iter_core_if.slave bus
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes_inv_iter_core: RPC must be 1, 2, 5 or 10");
  end
  if ((NR % RPC) != 0) begin : g_bad_nr
    $error("aes_inv_iter_core: NR must be a multiple of RPC");
  end

  core_state_e fsm_q, fsm_d;
  logic [3:0]  ctr_q, ctr_d;
  aes_state_t  blk_q, blk_d;
  aes_state_t  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  aes_state_t  key_q [NR+1];
  aes_state_t  key_d [NR+1];
  aes_state_t  chain_s [RPC+1];
  logic        in_ready_s;
  logic        key_we_s;

  assign in_ready_s = (fsm_q == ST_IDLE) && !bus.key_wr;
  assign key_we_s   = bus.key_wr && (fsm_q == ST_IDLE) && (int'(bus.key_idx) <= NR);
  assign chain_s[0] = blk_q;

  // Stage g handles round ctr-g; keys are picked by a one-hot OR so out-of-range indices read zero.
  for (genvar g = 0; g < RPC; g++) begin : g_round
    logic [3:0] ridx_s;
    aes_state_t rkey_s;

    assign ridx_s = ctr_q - 4'(g);

    always_comb begin
      rkey_s = '0;
      for (int i = 0; i <= NR; i++) begin
        rkey_s = rkey_s | (key_q[i] & {BLOCK_W{ridx_s == 4'(i)}});
      end
    end

    aes_inv_round u_round (
      .state_i (chain_s[g]),
      .key_i   (rkey_s),
      .last_i  (ridx_s == 4'd0),
      .state_o (chain_s[g+1])
    );
  end

  always_comb begin
    for (int i = 0; i <= NR; i++) begin
      key_d[i] = (key_we_s && (bus.key_idx == 4'(i))) ? bus.key_data : key_q[i];
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    ctr_d       = ctr_q;
    blk_d       = blk_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_s) begin
          blk_d = bus.in_data ^ key_q[NR];
          ctr_d = 4'(NR - 1);
          fsm_d = ST_RUN;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        blk_d = chain_s[RPC];
        if (ctr_q == 4'(RPC - 1)) begin
          ctr_d       = 4'd0;
          out_data_d  = chain_s[RPC];
          out_valid_d = 1'b1;
          fsm_d       = ST_DONE;
        end else begin
          ctr_d = ctr_q - 4'(RPC);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        ctr_d       = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      ctr_q       <= 4'd0;
      blk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      key_q       <= '{default: '0};
    end else begin
      fsm_q       <= fsm_d;
      ctr_q       <= ctr_d;
      blk_q       <= blk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      key_q       <= key_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_iter_core.sv
// Bench for aes_inv_iter_core: one DUT per legal RPC sharing the key bus, checked against
// a byte-matrix AES inverse-cipher model whose S-box is derived from GF(2^8) inversion.
`timescale 1ns/1ps
module tb_aes_inv_iter_core;

  localparam int NDUT = 4;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic [127:0] in_data;
  logic         in_valid_a  [NDUT];
  logic         out_ready_a [NDUT];
  logic         in_ready_a  [NDUT];
  logic         out_valid_a [NDUT];
  logic [127:0] out_data_a  [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_m     [256];
  logic [7:0]   inv_sbox_m [256];
  logic [127:0] mk         [11];
  logic [127:0] exp_rk     [11];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int RPC_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_inv_iter_core_if bus ();
    assign bus.key_wr    = key_wr;
    assign bus.key_idx   = key_idx;
    assign bus.key_data  = key_data;
    assign bus.in_valid  = in_valid_a[g];
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready_a[g];
    assign in_ready_a[g]  = bus.in_ready;
    assign out_valid_a[g] = bus.out_valid;
    assign out_data_a[g]  = bus.out_data;
    aes_inv_iter_core #(.RPC(RPC_G), .NR(10)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic int rpc_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // S-box = affine(multiplicative inverse); the inverse table is its permutation inverse.
  task automatic build_tables();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (v != 0 && m_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[v]     = s;
      inv_sbox_m[s] = 8'(v);
    end
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rcon, 24'h000000};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ mk[10][127 - 8*(4*c + r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = inv_sbox_m[s[r][(c - r + 4) % 4]] ^ mk[rnd][127 - 8*(4*c + r) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = m_mul(t[r][c], 8'h0e) ^ m_mul(t[(r+1)%4][c], 8'h0b) ^
                      m_mul(t[(r+2)%4][c], 8'h0d) ^ m_mul(t[(r+3)%4][c], 8'h09);
      end else begin
        s = t;
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_wr   = 1'b0;
    key_idx  = 4'd0;
    key_data = '0;
    in_data  = '0;
    for (int k = 0; k < NDUT; k++) begin
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b0;
    end
  endtask

  task automatic load_keys(input logic [127:0] key);
    key_expand(key);
    for (int r = 0; r < 11; r++) begin
      key_wr   = 1'b1;
      key_idx  = 4'(r);
      key_data = exp_rk[r];
      tick();
      mk[r] = exp_rk[r];
    end
    key_wr = 1'b0;
  endtask

  // Sends one block to an idle DUT, waits (bounded) for the result, then takes it.
  task automatic run_block(input int k, input logic [127:0] ct, output logic [127:0] pt, output int lat);
    in_data       = ct;
    in_valid_a[k] = 1'b1;
    tick();
    in_valid_a[k] = 1'b0;
    lat = -1;
    pt  = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid_a[k]) begin
        lat = i;
        pt  = out_data_a[k];
        break;
      end
    end
    out_ready_a[k] = 1'b1;
    tick();
    out_ready_a[k] = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (in_ready_a[k] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready_a[k]);
      else n_pass++;
      n_checks++;
      if (out_valid_a[k] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid_a[k]);
      else n_pass++;
      n_checks++;
      if (out_data_a[k] !== 128'h0) $display("FAIL reset_out_data[%0d]: got %h expected 0", k, out_data_a[k]);
      else n_pass++;
    end
    for (int r = 0; r < 11; r++) mk[r] = '0;
  endtask

  task automatic test_fips_c1();
    int           lat [NDUT];
    logic [127:0] got [NDUT];
    load_keys(C1_KEY);
    in_data = C1_CT;
    for (int k = 0; k < NDUT; k++) in_valid_a[k] = 1'b1;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      in_valid_a[k] = 1'b0;
      lat[k] = -1;
      got[k] = '0;
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < NDUT; k++) begin
        if (lat[k] < 0 && out_valid_a[k]) begin
          lat[k] = i;
          got[k] = out_data_a[k];
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (lat[k] != 10 / rpc_of(k)) $display("FAIL c1_latency[rpc=%0d]: got %0d expected %0d", rpc_of(k), lat[k], 10 / rpc_of(k));
      else n_pass++;
      n_checks++;
      if (got[k] !== C1_PT) $display("FAIL c1_plaintext[rpc=%0d]: got %h expected %h", rpc_of(k), got[k], C1_PT);
      else n_pass++;
      out_ready_a[k] = 1'b1;
    end
    tick();
    for (int k = 0; k < NDUT; k++) begin
      out_ready_a[k] = 1'b0;
      n_checks++;
      if (out_valid_a[k] !== 1'b0) $display("FAIL c1_release[rpc=%0d]: got %b expected 0", rpc_of(k), out_valid_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure(input int k);
    logic [127:0] second;
    int           lat;
    second        = rand128();
    in_data       = C1_CT;
    in_valid_a[k] = 1'b1;
    tick();
    in_data = second;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid_a[k]) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != 10 / rpc_of(k)) $display("FAIL bp_latency[rpc=%0d]: got %0d expected %0d", rpc_of(k), lat, 10 / rpc_of(k));
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (out_valid_a[k] !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid_a[k]);
      else n_pass++;
      n_checks++;
      if (out_data_a[k] !== C1_PT) $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, out_data_a[k], C1_PT);
      else n_pass++;
      n_checks++;
      if (in_ready_a[k] !== 1'b0) $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", i, in_ready_a[k]);
      else n_pass++;
    end
    out_ready_a[k] = 1'b1;
    tick();
    out_ready_a[k] = 1'b0;
    n_checks++;
    if (out_valid_a[k] !== 1'b0) $display("FAIL bp_out_released: got %b expected 0", out_valid_a[k]);
    else n_pass++;
    n_checks++;
    if (in_ready_a[k] !== 1'b1) $display("FAIL bp_in_ready_after: got %b expected 1", in_ready_a[k]);
    else n_pass++;
    tick();
    in_valid_a[k] = 1'b0;
    n_checks++;
    if (in_ready_a[k] !== 1'b0) $display("FAIL bp_second_accepted: got in_ready %b expected 0", in_ready_a[k]);
    else n_pass++;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid_a[k]) begin
        lat = i;
        break;
      end
      tick();
    end
    n_checks++;
    if (lat < 0 || out_data_a[k] !== ref_decrypt(second))
      $display("FAIL bp_second_block: got %h expected %h", out_data_a[k], ref_decrypt(second));
    else n_pass++;
    out_ready_a[k] = 1'b1;
    tick();
    out_ready_a[k] = 1'b0;
  endtask

  task automatic test_key_lockout();
    logic [127:0] got;
    int           lat;
    in_data       = C1_CT;
    in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    key_wr   = 1'b1;
    key_idx  = 4'd10;
    key_data = '1;
    tick();
    key_wr = 1'b0;
    lat = -1;
    got = '0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (out_valid_a[0]) begin
        lat = i;
        got = out_data_a[0];
        break;
      end
    end
    n_checks++;
    if (got !== C1_PT || lat != 10) $display("FAIL lockout_inflight: got %h lat %0d expected %h lat 10", got, lat, C1_PT);
    else n_pass++;
    out_ready_a[0] = 1'b1;
    tick();
    out_ready_a[0] = 1'b0;
    run_block(0, C1_CT, got, lat);
    n_checks++;
    if (got !== C1_PT) $display("FAIL lockout_next_block: got %h expected %h", got, C1_PT);
    else n_pass++;
    load_keys(C1_KEY);
  endtask

  task automatic test_illegal_idx();
    logic [127:0] got;
    int           lat;
    for (int idx = 11; idx <= 15; idx++) begin
      key_wr   = 1'b1;
      key_idx  = 4'(idx);
      key_data = rand128();
      #1;
      n_checks++;
      if (in_ready_a[0] !== 1'b0) $display("FAIL keywr_blocks_in_ready[%0d]: got %b expected 0", idx, in_ready_a[0]);
      else n_pass++;
      tick();
    end
    key_wr = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      run_block(k, C1_CT, got, lat);
      n_checks++;
      if (got !== C1_PT) $display("FAIL illegal_idx_decrypt[rpc=%0d]: got %h expected %h", rpc_of(k), got, C1_PT);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic         saw;
    logic [127:0] got;
    logic [127:0] ct;
    int           lat;
    in_data       = C1_CT;
    in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid_a[k] !== 1'b0 || out_data_a[k] !== 128'h0)
        $display("FAIL async_reset[%0d]: got valid %b data %h expected 0/0", k, out_valid_a[k], out_data_a[k]);
      else n_pass++;
    end
    tick();
    rst = 1'b0;
    for (int r = 0; r < 11; r++) mk[r] = '0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      for (int k = 0; k < NDUT; k++) if (out_valid_a[k]) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL reset_discard: got out_valid seen %b expected 0", saw);
    else n_pass++;
    run_block(0, C1_CT, got, lat);
    n_checks++;
    if (got !== ref_decrypt(C1_CT)) $display("FAIL zero_key_c1: got %h expected %h", got, ref_decrypt(C1_CT));
    else n_pass++;
    ct = rand128();
    run_block(3, ct, got, lat);
    n_checks++;
    if (got !== ref_decrypt(ct)) $display("FAIL zero_key_rand: got %h expected %h", got, ref_decrypt(ct));
    else n_pass++;
    load_keys(C1_KEY);
  endtask

  task automatic test_back_to_back(input int k);
    logic [127:0] exp_q [$];
    logic [127:0] od;
    logic [127:0] exp_v;
    logic         acc;
    logic         ohs;
    logic         extra;
    int           sent;
    int           recv;
    int           cyc;
    key_expand(rand128());
    load_keys(exp_rk[0]);
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 16 && cyc < 3000) begin
      in_valid_a[k]  = (sent < 16) && ($urandom_range(0, 3) != 0);
      in_data        = rand128();
      out_ready_a[k] = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid_a[k] && in_ready_a[k];
      ohs = out_valid_a[k] && out_ready_a[k];
      od  = out_data_a[k];
      if (acc) begin
        exp_q.push_back(ref_decrypt(in_data));
        sent++;
      end
      tick();
      cyc++;
      if (ohs) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        recv++;
        n_checks++;
        if (od !== exp_v) $display("FAIL b2b_data[rpc=%0d,#%0d]: got %h expected %h", rpc_of(k), recv, od, exp_v);
        else n_pass++;
      end
    end
    in_valid_a[k]  = 1'b0;
    out_ready_a[k] = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid_a[k]) extra = 1'b1;
    end
    out_ready_a[k] = 1'b0;
    n_checks++;
    if (recv != 16 || exp_q.size() != 0 || extra !== 1'b0)
      $display("FAIL b2b_count[rpc=%0d]: got recv %0d pending %0d extra %b expected 16/0/0", rpc_of(k), recv, exp_q.size(), extra);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    build_tables();
    test_reset();
    test_fips_c1();
    test_backpressure(0);
    test_backpressure(1);
    test_key_lockout();
    test_illegal_idx();
    test_reset_mid_run();
    for (int k = 0; k < NDUT; k++) test_back_to_back(k);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_iter_core.md
AES_INV_ITER_CORE -- requirements
Module: aes_inv_iter_core

Interface
REQ-001 SHALL have parameter: RPC, 1, inverse rounds per clock; legal values 1, 2, 5, 10; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter: NR, 10, round count; fixed for AES-128, exposed for the planned AES-192/256 successor.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 key_wr  in  1  round-key write strobe.
REQ-007 key_idx  in  4  round-key index 0..NR.
REQ-008 key_data  in  128  round key, byte 0 in [127:120].
REQ-009 in_valid  in  1  ciphertext valid.
REQ-010 in_ready  out  1  core accepts ciphertext.
REQ-011 in_data  in  128  ciphertext, FIPS-197 column-major order, byte 0 in [127:120].
REQ-012 out_valid  out  1  plaintext valid.
REQ-013 out_ready  in  1  consumer accepts plaintext.
REQ-014 out_data  out  128  plaintext, same byte order as in_data.

Function
REQ-015 SHALL hold NR+1 128-bit round-key registers written on clk when key_wr=1 and state=IDLE; writes with key_idx>NR or state!=IDLE SHALL be dropped silently.
REQ-016 SHALL implement the FSM: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with key_wr=0.
REQ-018 An input handshake (in_valid & in_ready) SHALL load state = in_data ^ key[NR], load round counter = NR-1 and move to RUN.
REQ-019 Each RUN cycle SHALL apply RPC inverse rounds, each round being InvShiftRows, then InvSubBytes, then AddRoundKey(key[r]), then InvMixColumns for r>=1.
REQ-020 InvMixColumns SHALL be omitted for r=0.
REQ-021 The round counter SHALL decrement by RPC per RUN cycle.
REQ-022 After the cycle that applies r=0, the FSM SHALL enter DONE with out_data registered.
REQ-023 Latency from the handshake edge to out_valid=1 SHALL be exactly NR/RPC cycles (10, 5, 2 or 1).
REQ-024 In DONE, out_valid=1 and out_data SHALL stay stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-025 A new input SHALL NOT be accepted in the same cycle as the output handshake; peak throughput SHALL be one block per NR/RPC+2 cycles.
REQ-026 in_valid during RUN or DONE SHALL be ignored, and in_data need not be held by the core.
REQ-027 Round keys SHALL be read combinationally from the key registers; key contents SHALL be stable across a block because writes are blocked outside IDLE.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, round counter=0, out_valid=0, out_data=0 and all key registers=0.
REQ-029 In-flight and undelivered blocks SHALL be discarded on reset.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst deasserts.

Structure
REQ-031 A shared package aes_pkg SHALL hold the inverse S-box table, xtime/GF multiply functions, the state typedef, and the constants NR_AES128=10 and BLOCK_W=128.
REQ-032 The package SHALL be reused by the existing forward and inverse combinational blocks.
REQ-033 One combinational sub-module aes_inv_round SHALL implement a single round (inputs: state, key, last_round flag), instantiated RPC times in a chain.
REQ-034 The FSM, counter and key file SHALL live in aes_inv_iter_core.

Verification
REQ-035 FIPS-197 C.1: keys 0..10 loaded from key 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff after exactly NR/RPC cycles, for every legal RPC.
REQ-036 Backpressure: out_ready=0 for 7 cycles after out_valid -> out_data stable and in_ready=0 throughout; on the handshake, in_ready=1 the next cycle.
REQ-037 Key lockout: key_wr to idx 10 with all-ones data during RUN -> write dropped, and the next block still decrypts the C.1 vector correctly.
REQ-038 Reset mid-RUN: rst pulsed at cycle 3 of a block -> out_valid=0, no output produced, keys read back as zero (C.1 decrypt with zero keys matches a software model).
REQ-039 Back-to-back: 16 random blocks under random in_valid/out_ready -> outputs in order and bit-exact against the reference model, with no drops or duplicates.
REQ-040 Illegal index: key_wr with key_idx=11..15 -> no key register changes.
